// File: rtl/apb_pkg.sv
// Shared definitions for the APB master/slave subsystem: FSM state encoding
// and default bus widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned WAIT_CNT_W     = 4;

endpackage

// File: rtl/apb_mem_slave.sv
// APB register-file slave: word memory plus a wait counter that holds off
// P_ready for WAIT_STATES extra ACCESS cycles.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_width  = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_width  = DATA_WIDTH_DEF,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  P_clk,
  input  logic                  P_reset_n,
  input  logic                  P_sel,
  input  logic                  P_enable,
  input  logic                  P_write,
  input  logic [ADDR_width-1:0] P_addr,
  input  logic [DATA_width-1:0] P_wdata,
  output logic [DATA_width-1:0] P_rdata,
  output logic                  P_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_width;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_STATES);

  logic [DATA_width-1:0] mem_q [DEPTH];
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  access;

  assign access  = P_sel & P_enable;
  assign P_ready = access && (wait_cnt_q == WAIT_LIMIT);
  assign P_rdata = mem_q[P_addr];

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (access) begin
      wait_cnt_d = P_ready ? '0 : wait_cnt_q + WAIT_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) wait_cnt_q <= '0;
    else            wait_cnt_q <= wait_cnt_d;
  end

  // NOTE: the memory is reset because unwritten words must read back as zero.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (P_ready && P_write) begin
      mem_q[P_addr] <= P_wdata;
    end
  end

endmodule

// File: rtl/apb_protocol.sv
// APB subsystem top: request latch and master FSM driving the internal
// memory slave, one transfer per request with back-to-back chaining.
module apb_protocol
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_width  = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_width  = DATA_WIDTH_DEF,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  P_clk,
  input  logic                  P_reset_n,
  input  logic                  start_transfer,
  input  logic                  rw,
  input  logic [ADDR_width-1:0] addr,
  input  logic [DATA_width-1:0] wdata,
  output logic [DATA_width-1:0] rdata,
  output logic                  busy,
  output logic                  valid,
  output logic                  P_sel,
  output logic                  P_enable,
  output logic                  P_ready
);

  apb_state_e            state_q, state_d;
  logic                  rw_q;
  logic [ADDR_width-1:0] addr_q;
  logic [DATA_width-1:0] wdata_q;
  logic [DATA_width-1:0] rdata_q;
  logic                  valid_q, sel_q, enable_q;
  logic                  take_req, complete;
  logic [DATA_width-1:0] slave_rdata;

  always_comb begin
    state_d  = state_q;
    take_req = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_transfer) begin
          take_req = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (P_ready) begin
          complete = 1'b1;
          // A new request at the completion edge chains without an IDLE cycle.
          if (start_transfer) begin
            take_req = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      enable_q <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= (state_d != IDLE);
      enable_q <= (state_d == ACCESS);
      valid_q  <= complete && !rw_q;
      if (take_req) begin
        rw_q    <= rw;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (complete && !rw_q) rdata_q <= slave_rdata;
    end
  end

  assign P_sel    = sel_q;
  assign P_enable = enable_q;
  assign busy     = (state_q != IDLE);
  assign valid    = valid_q;
  assign rdata    = rdata_q;

  apb_mem_slave #(
    .ADDR_width (ADDR_width),
    .DATA_width (DATA_width),
    .WAIT_STATES(WAIT_STATES)
  ) u_slave (
    .P_clk    (P_clk),
    .P_reset_n(P_reset_n),
    .P_sel    (sel_q),
    .P_enable (enable_q),
    .P_write  (rw_q),
    .P_addr   (addr_q),
    .P_wdata  (wdata_q),
    .P_rdata  (slave_rdata),
    .P_ready  (P_ready)
  );

endmodule

// File: tb/tb_apb_protocol.sv
// Self-checking bench for apb_protocol: two instances (0 and 2 wait states)
// checked cycle by cycle against a transaction-level timeline and memory model.
module tb_apb_protocol;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start_s [2];
  logic          rw_s    [2];
  logic [AW-1:0] addr_s  [2];
  logic [DW-1:0] wdata_s [2];
  logic [DW-1:0] rdata_w [2];
  logic          busy_w  [2];
  logic          valid_w [2];
  logic          sel_w   [2];
  logic          en_w    [2];
  logic          rdy_w   [2];

  apb_protocol #(.ADDR_width(AW), .DATA_width(DW), .WAIT_STATES(0)) dut0 (
    .P_clk(clk), .P_reset_n(rst_n), .start_transfer(start_s[0]), .rw(rw_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_w[0]), .busy(busy_w[0]),
    .valid(valid_w[0]), .P_sel(sel_w[0]), .P_enable(en_w[0]), .P_ready(rdy_w[0])
  );

  apb_protocol #(.ADDR_width(AW), .DATA_width(DW), .WAIT_STATES(2)) dut2 (
    .P_clk(clk), .P_reset_n(rst_n), .start_transfer(start_s[1]), .rw(rw_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_w[1]), .busy(busy_w[1]),
    .valid(valid_w[1]), .P_sel(sel_w[1]), .P_enable(en_w[1]), .P_ready(rdy_w[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-instance memory image, expected rdata and valid.
  logic [DW-1:0] model_mem [2][16];
  logic [DW-1:0] exp_rdata [2];
  logic          exp_valid;

  // Request list consumed by run_seq.
  logic          req_rw    [8];
  logic [AW-1:0] req_addr  [8];
  logic [DW-1:0] req_wdata [8];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Packed observation: {P_sel, P_enable, P_ready, busy, valid, rdata}.
  function automatic logic [12:0] obs(input int d);
    return {sel_w[d], en_w[d], rdy_w[d], busy_w[d], valid_w[d], rdata_w[d]};
  endfunction

  task automatic drive_req(input int d, input logic s, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    start_s[d] = s; rw_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) model_mem[d][i] = '0;
      exp_rdata[d] = '0;
    end
    exp_valid = 1'b0;
  endtask

  task automatic model_complete(input int d, input int k);
    if (req_rw[k]) begin
      model_mem[d][req_addr[k]] = req_wdata[k];
      exp_valid = 1'b0;
    end else begin
      exp_rdata[d] = model_mem[d][req_addr[k]];
      exp_valid = 1'b1;
    end
  endtask

  // Issues n chained requests on instance d (entered and left at a negedge).
  // Each transfer: one SETUP cycle, then WAIT_STATES+1 ACCESS cycles with
  // P_ready only in the last; inputs are scrambled while they must be ignored.
  task automatic run_seq(input int d, input int n, input string name);
    int ws;
    logic [12:0] act, exp;
    ws = ws_of(d);
    drive_req(d, 1'b1, req_rw[0], req_addr[0], req_wdata[0]);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c <= ws + 1; c++) begin
        @(posedge clk);
        if (c == 0 && k > 0) model_complete(d, k - 1);
        else                 exp_valid = 1'b0;
        @(negedge clk);
        exp = {1'b1, (c != 0), (c == ws + 1), 1'b1, exp_valid, exp_rdata[d]};
        act = obs(d);
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL %s dut%0d xfer%0d cyc%0d {sel,en,rdy,busy,valid,rdata}: got %h expected %h",
                   name, d, k, c, act, exp);
        end
        if (c == ws + 1) begin
          if (k < n - 1) drive_req(d, 1'b1, req_rw[k+1], req_addr[k+1], req_wdata[k+1]);
          else           drive_req(d, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
        end else begin
          drive_req(d, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
        end
      end
    end
    @(posedge clk);
    model_complete(d, n - 1);
    @(negedge clk);
    exp = {4'b0000, exp_valid, exp_rdata[d]};
    act = obs(d);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d done {sel,en,rdy,busy,valid,rdata}: got %h expected %h",
               name, d, act, exp);
    end
    drive_req(d, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    exp_valid = 1'b0;
    @(negedge clk);
    exp = {5'b00000, exp_rdata[d]};
    act = obs(d);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d idle {sel,en,rdy,busy,valid,rdata}: got %h expected %h",
               name, d, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 13'h0) begin
        failures++;
        $display("FAIL reset_hold dut%0d: got %h expected %h", d, obs(d), 13'h0);
      end
    end
    #17 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 13'h0) begin
        failures++;
        $display("FAIL reset_release dut%0d: got %h expected %h", d, obs(d), 13'h0);
      end
    end
  endtask

  task automatic test_write_pair();
    req_rw[0] = 1'b1; req_addr[0] = 4'hA; req_wdata[0] = 8'h55;
    run_seq(0, 1, "write_A");
    req_rw[0] = 1'b1; req_addr[0] = 4'hB; req_wdata[0] = 8'h56;
    run_seq(0, 1, "write_B");
  endtask

  task automatic test_back_to_back();
    req_rw[0] = 1'b0; req_addr[0] = 4'hA; req_wdata[0] = 8'h00;
    req_rw[1] = 1'b0; req_addr[1] = 4'hB; req_wdata[1] = 8'h00;
    run_seq(0, 2, "b2b_read");
    checks++;
    if (rdata_w[0] !== 8'h56) begin
      failures++;
      $display("FAIL b2b_last_rdata: got %h expected %h", rdata_w[0], 8'h56);
    end
  endtask

  task automatic test_unwritten();
    req_rw[0] = 1'b0; req_addr[0] = 4'h3; req_wdata[0] = 8'hFF;
    run_seq(0, 1, "read_unwritten");
  endtask

  task automatic test_wait_states();
    req_rw[0] = 1'b1; req_addr[0] = 4'h1; req_wdata[0] = 8'h12;
    req_rw[1] = 1'b0; req_addr[1] = 4'h1; req_wdata[1] = 8'h00;
    run_seq(1, 2, "ws2_write_read");
    checks++;
    if (rdata_w[1] !== 8'h12) begin
      failures++;
      $display("FAIL ws2_rdata: got %h expected %h", rdata_w[1], 8'h12);
    end
  endtask

  task automatic test_reset_during_access();
    logic [12:0] exp;
    drive_req(1, 1'b1, 1'b1, 4'h5, 8'h99);
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 1'b0, 1'b1, 4'h5, 8'h99);
    @(posedge clk);
    @(negedge clk);
    exp = {4'b1101, 1'b0, exp_rdata[1]};
    checks++;
    if (obs(1) !== exp) begin
      failures++;
      $display("FAIL abort_in_access dut1: got %h expected %h", obs(1), exp);
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 13'h0) begin
        failures++;
        $display("FAIL abort_reset dut%0d: got %h expected %h", d, obs(d), 13'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_rw[0] = 1'b0; req_addr[0] = 4'h5; req_wdata[0] = 8'h00;
    run_seq(1, 1, "read_after_abort");
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int d, n;
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        req_rw[k]    = 1'($urandom);
        req_addr[k]  = AW'($urandom_range(0, 7));
        req_wdata[k] = DW'($urandom);
      end
      run_seq(d, n, "random");
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) drive_req(d, 1'b0, 1'b0, '0, '0);
    model_reset();
    test_reset();
    test_write_pair();
    test_back_to_back();
    test_unwritten();
    test_wait_states();
    test_reset_during_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
